twos_comp_deserializer: RTL and testbench
=========================================

Name: twos_comp_deserializer

Overview:
- Receive end of the serial two's-complement link. Takes the LSB-first serial stream produced by the bit-serial complementer and undoes the complement on the fly, so the original word is recovered.
- Assembles the recovered bits into a parallel WIDTH-bit word, pulses data_valid when the word is complete, and flags the two self-complementing corner words.
- Sits directly downstream of the serial complementer output.

Parameters:
- WIDTH, 16, data bits per frame (2 or more).
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH (plus 1 when PARITY_EN is defined).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- start  input  1  frame start; begins a new frame, aborting any frame in progress.
- x  input  1  serial data bit, LSB first; sampled only when x_valid=1.
- x_valid  input  1  bit strobe; one bit per clock at which it is high.
- data_out  output  WIDTH  recovered word; holds its value until the next frame completes.
- data_valid  output  1  one-clock pulse: data_out has been updated.
- busy  output  1  high while a frame is open (states COPY or INVERT).
- zero_flag  output  1  completed word was 0; registered alongside data_out.
- min_flag  output  1  completed word was 1 followed by WIDTH-1 zeros (most negative); registered alongside data_out.
- parity_err  output  1  only present with PARITY_EN; registered alongside data_out.

Behaviour:
- Reset (asynchronous): state=IDLE, bit count=0, shift register=0.
  - All outputs return to 0: data_out=0, data_valid=0, busy=0, zero_flag=0, min_flag=0, parity_err=0.
  - Reset asserted mid-frame discards the partial word; no data_valid is produced.
- States:
  - IDLE: wait for start.
  - COPY: no 1 has been seen yet in this frame.
  - INVERT: a 1 has been seen in this frame.
- Transitions:
  - IDLE -> COPY when start=1.
  - start=1 in COPY or INVERT: return to COPY, clear the count and shift register, abort the old frame. No data_valid for the aborted frame.
  - start and x_valid both high in the same clock: x is bit 0 of the new frame.
- Per accepted bit (x_valid=1 in COPY or INVERT, or in the start clock):
  - COPY: decoded bit d=x; if x=1, move to INVERT.
  - INVERT: d=~x.
  - d enters the shift register at the MSB and the register shifts right, so after WIDTH bits, bit 0 sits at data_out[0].
  - Increment the count.
- x_valid=0: no shift, no count change, no state change. Gaps in the strobe are allowed.
- x_valid while IDLE: ignored.
- Completion, on the clock that accepts the last bit:
  - The following clock has data_out = assembled word, data_valid=1 for exactly one clock, and state=IDLE, busy=0.
  - zero_flag=1 iff the frame ended in COPY (all input bits 0).
  - min_flag=1 iff the transition to INVERT occurred on the final data bit.
- Back-to-back frames: start may be asserted in the same clock as data_valid; the new frame opens with no lost bits.
- Arithmetic: output = (2^WIDTH - input) mod 2^WIDTH. Inputs 0 and 2^(WIDTH-1) decode to themselves.

Optional Feature:
- Macro: TWOS_DESER_PARITY_EN.
- Defined:
  - Each frame carries WIDTH+1 bits; the last bit is an even-parity bit over the WIDTH received (undecoded) bits.
  - The parity bit does not pass through the COPY/INVERT logic and does not shift into data_out.
  - parity_err registers with data_valid: 1 if parity fails, else 0.
  - The zero_flag and min_flag conditions are evaluated at the last data bit, not at the parity bit.
- Undefined: the frame is WIDTH bits, the parity_err port is absent, and there is no parity logic.

Test Plan:
- Basic decode: start, then 16 consecutive bits of 16'h4D4B LSB-first -> one clock after the last bit, data_out=16'hB2B5, data_valid pulse of 1 clock, zero_flag=0, min_flag=0, busy=0.
- Corner words: frame 16'h0000 -> data_out=16'h0000, zero_flag=1. Frame 16'h8000 -> data_out=16'h8000, min_flag=1, zero_flag=0.
- Strobe gaps: 16'h0001 sent with x_valid=0 for 3 clocks after bit 4 and 1 clock after bit 11 -> data_out=16'hFFFF; data_valid arrives exactly 4 clocks later than in the gap-free case.
- Abort and back-to-back:
  - 5 bits of 16'hFFFF, then start again, then a full frame of 16'h0002 -> single data_valid, data_out=16'hFFFE.
  - Then start asserted in the data_valid clock, followed by 16'h4D4B -> second pulse with 16'hB2B5.
- Reset mid-frame: reset pulse after 9 bits -> all outputs 0 within the reset clock, no data_valid; a following full frame of 16'h4D4B decodes correctly.
- TWOS_DESER_PARITY_EN:
  - 16'h4D4B plus correct parity bit 0 (eight ones) -> parity_err=0.
  - Same frame with parity bit 1 -> parity_err=1, data_out=16'hB2B5.

Source files
------------

// File: rtl/twos_comp_deserializer.sv
// Two's-complement deserializer: undoes a bit-serial LSB-first complement
// on the fly and assembles the recovered bits into a parallel word.
//
// Ports:
//   clk, reset (async, active-high)
//   start      - open a new frame, aborting any open one
//   x, x_valid - serial bit (LSB first) and its strobe
//   data_out   - recovered word, held until the next frame completes
//   data_valid - one-clock pulse when data_out is updated
//   busy       - frame open (COPY or INVERT)
//   zero_flag  - completed word was 0
//   min_flag   - completed word was the most negative value
//   parity_err - even-parity failure (only with TWOS_DESER_PARITY_EN)
//
// Option: define TWOS_DESER_PARITY_EN to append one even-parity bit
// per frame (computed over the raw received data bits).

module twos_comp_deserializer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             x,
    input  logic             x_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             zero_flag,
    output logic             min_flag
`ifdef TWOS_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COPY   = 2'd1,
        INVERT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

`ifdef TWOS_DESER_PARITY_EN
    // The assembled word must survive one extra clock for the parity bit.
    localparam int SR_W = WIDTH;
    localparam logic [CNT_W-1:0] PAR_IDX = CNT_W'(WIDTH);
`else
    // The final bit goes straight to data_out, so one bit less is stored.
    localparam int SR_W = WIDTH - 1;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               valid_q, valid_d;
    logic               zero_q, zero_d;
    logic               min_q, min_d;

`ifdef TWOS_DESER_PARITY_EN
    logic               par_q, par_d;
    logic               minp_q, minp_d;
    logic               perr_q, perr_d;
    logic               par_eff;
`endif

    // Frame context as seen this clock: start wipes it before the bit.
    state_t             st_eff;
    logic [CNT_W-1:0]   cnt_eff;
    logic [SR_W-1:0]    sr_eff;
    logic               dbit;
    logic [WIDTH-1:0]   shifted;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        zero_d  = zero_q;
        min_d   = min_q;
        st_eff  = state_q;
        cnt_eff = cnt_q;
        sr_eff  = sr_q;
`ifdef TWOS_DESER_PARITY_EN
        par_d   = par_q;
        minp_d  = minp_q;
        perr_d  = perr_q;
        par_eff = par_q;
`endif

        if (start) begin
            st_eff  = COPY;
            cnt_eff = '0;
            sr_eff  = '0;
            state_d = COPY;
            cnt_d   = '0;
            sr_d    = '0;
`ifdef TWOS_DESER_PARITY_EN
            par_eff = 1'b0;
            par_d   = 1'b0;
`endif
        end

        // Bits pass unchanged up to and including the first 1,
        // and are inverted after it.
        dbit = (st_eff == COPY) ? x : ~x;
`ifdef TWOS_DESER_PARITY_EN
        shifted = {dbit, sr_eff[SR_W-1:1]};
`else
        shifted = {dbit, sr_eff};
`endif

        if (x_valid && st_eff != IDLE) begin
`ifdef TWOS_DESER_PARITY_EN
            if (cnt_eff == PAR_IDX) begin
                dout_d  = sr_eff;
                perr_d  = par_eff ^ x;
                zero_d  = (st_eff == COPY);
                min_d   = minp_q;
                valid_d = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
                sr_d    = '0;
                par_d   = 1'b0;
            end else begin
                sr_d  = shifted;
                cnt_d = cnt_eff + CNT_W'(1);
                par_d = par_eff ^ x;
                if (st_eff == COPY && x) begin
                    state_d = INVERT;
                end
                if (cnt_eff == LAST_DATA) begin
                    minp_d = (st_eff == COPY) && x;
                end
            end
`else
            if (cnt_eff == LAST_DATA) begin
                dout_d  = shifted;
                zero_d  = (st_eff == COPY) && !x;
                min_d   = (st_eff == COPY) && x;
                valid_d = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
                sr_d    = '0;
            end else begin
                sr_d  = shifted[WIDTH-1:1];
                cnt_d = cnt_eff + CNT_W'(1);
                if (st_eff == COPY && x) begin
                    state_d = INVERT;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            min_q   <= 1'b0;
`ifdef TWOS_DESER_PARITY_EN
            par_q   <= 1'b0;
            minp_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
            min_q   <= min_d;
`ifdef TWOS_DESER_PARITY_EN
            par_q   <= par_d;
            minp_q  <= minp_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign busy       = (state_q != IDLE);
    assign zero_flag  = zero_q;
    assign min_flag   = min_q;
`ifdef TWOS_DESER_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_twos_comp_deserializer.sv
// Self-checking bench for twos_comp_deserializer: directed corner frames
// plus random frames with random strobe gaps against a negation model.

module tb_twos_comp_deserializer;

    localparam int W = 16;
`ifdef TWOS_DESER_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         x;
    logic         x_valid;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         busy;
    logic         zero_flag;
    logic         min_flag;
`ifdef TWOS_DESER_PARITY_EN
    logic         parity_err;
`endif

    twos_comp_deserializer #(.WIDTH(W), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x          (x),
        .x_valid    (x_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .zero_flag  (zero_flag),
        .min_flag   (min_flag)
`ifdef TWOS_DESER_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nvalid = 0;
    int exp_nvalid = 0;

    always @(negedge clk) begin
        if (data_valid === 1'b1) nvalid++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the recovered word is the modular negation of the input.
    function automatic logic [W-1:0] ref_dec(input logic [W-1:0] w);
        longint m;
        m = longint'(1) << W;
        return W'((m - longint'(w)) % m);
    endfunction

    // Drive nbits of a frame; extra gaps before bit 5 and bit 12.
    task automatic send(input logic [W-1:0] w, input int nbits,
                        input int g5, input int g12,
                        input bit rnd, input bit flip);
        logic [NB-1:0] fr;
        int g;
`ifdef TWOS_DESER_PARITY_EN
        fr = {(^w) ^ flip, w};
`else
        fr = w;
`endif
        for (int i = 0; i < nbits; i++) begin
            g = (i == 5 ? g5 : 0) + (i == 12 ? g12 : 0);
            if (rnd && i > 0 && $urandom_range(0, 3) == 0)
                g += $urandom_range(1, 3);
            for (int k = 0; k < g; k++) begin
                start   = 1'b0;
                x_valid = 1'b0;
                x       = 1'($urandom);
                tick();
                chk("gap_valid", 32'(data_valid), 32'd0);
            end
            start   = (i == 0);
            x_valid = 1'b1;
            x       = fr[i];
            tick();
            start   = 1'b0;
            x_valid = 1'b0;
            if (i < NB - 1) begin
                chk("early_valid", 32'(data_valid), 32'd0);
                if (i == 0) chk("busy_open", 32'(busy), 32'd1);
            end
        end
    endtask

    task automatic expect_done(input logic [W-1:0] w, input bit flip);
        exp_nvalid++;
        chk("valid", 32'(data_valid), 32'd1);
        chk("data", 32'(data_out), 32'(ref_dec(w)));
        chk("zero", 32'(zero_flag), 32'(w == '0));
        chk("min", 32'(min_flag), 32'(w == (W'(1) << (W - 1))));
        chk("busy_done", 32'(busy), 32'd0);
`ifdef TWOS_DESER_PARITY_EN
        chk("perr", 32'(parity_err), 32'(flip));
`endif
    endtask

    task automatic frame(input logic [W-1:0] w, input bit flip);
        send(w, NB, 0, 0, 1'b0, flip);
        expect_done(w, flip);
        tick();
        chk("pulse_len", 32'(data_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] w;
        bit           fl;
        reset   = 1'b1;
        start   = 1'b0;
        x       = 1'b0;
        x_valid = 1'b0;
        tick();
        tick();
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_zero", 32'(zero_flag), 32'd0);
        chk("rst_min", 32'(min_flag), 32'd0);
        reset = 1'b0;
        tick();

        // Strobe while idle must be ignored.
        x_valid = 1'b1;
        x       = 1'b1;
        repeat (3) tick();
        x_valid = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(data_valid), 32'd0);

        frame(16'h4D4B, 1'b0);
        chk("basic_lit", 32'(data_out), 32'h0000B2B5);
        frame(16'h0000, 1'b0);
        frame(16'h8000, 1'b0);
        frame(16'h0001, 1'b0);

        // Gapped frame: pulse only after the four extra clocks.
        send(16'h0001, NB, 3, 1, 1'b0, 1'b0);
        expect_done(16'h0001, 1'b0);
        chk("gap_lit", 32'(data_out), 32'h0000FFFF);
        tick();

        // Abort then back-to-back.
        send(16'hFFFF, 5, 0, 0, 1'b0, 1'b0);
        send(16'h0002, NB, 0, 0, 1'b0, 1'b0);
        expect_done(16'h0002, 1'b0);
        send(16'h4D4B, NB, 0, 0, 1'b0, 1'b0);
        expect_done(16'h4D4B, 1'b0);
        tick();

`ifdef TWOS_DESER_PARITY_EN
        frame(16'h4D4B, 1'b1);
        chk("perr_data", 32'(data_out), 32'h0000B2B5);
        frame(16'h4D4B, 1'b0);
`endif

        // Reset mid-frame clears everything at once.
        send(16'h1234, 9, 0, 0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("mrst_data", 32'(data_out), 32'd0);
        chk("mrst_valid", 32'(data_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_zero", 32'(zero_flag), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        frame(16'h4D4B, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: w = '0;
                1: w = W'(1) << (W - 1);
                default: w = W'($urandom);
            endcase
`ifdef TWOS_DESER_PARITY_EN
            fl = 1'($urandom);
`else
            fl = 1'b0;
`endif
            send(w, NB, 0, 0, 1'b1, fl);
            expect_done(w, fl);
            if ($urandom_range(0, 1) == 0) begin
                tick();
                chk("pulse_len", 32'(data_valid), 32'd0);
            end
        end

        repeat (3) tick();
        chk("pulse_count", 32'(nvalid), 32'(exp_nvalid));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
